// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scan controller: one BCD digit per slot with dead time, leading-zero blanking
// and frame-aligned commit of new data. Outputs are registered one cycle from state; load_ready = !pending_valid.
module bcd_display_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int PRESCALE         = 1000,
    parameter int BLANK_CYCLES     = 16,
    parameter int DIGIT_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    lzb_en,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    blank,
    output logic                    frame_done
);

    localparam int ON_CYCLES = PRESCALE - BLANK_CYCLES;
    localparam int CW        = $clog2(PRESCALE);
    localparam int IW        = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_OFF =
        (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic {S_BLANK, S_ON} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;

    state_t                  state_n;
    logic [CW-1:0]           cnt_n;
    logic [IW-1:0]           idx_n;
    logic                    boundary;
    logic                    take;
    logic                    pv_n;
    logic [4*NUM_DIGITS-1:0] active_n;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    zero_run;
    logic [3:0]              digit_n;
    logic                    hide_n;
    logic [NUM_DIGITS-1:0]   onehot_n;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        boundary = 1'b0;
        if (state == S_BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_n = S_ON;
                cnt_n   = '0;
            end
        end else begin
            if (cnt == ON_LAST) begin
                state_n  = S_BLANK;
                cnt_n    = '0;
                boundary = (idx == IDX_LAST);
                idx_n    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Commit uses the pre-transfer pending_valid, so a load taken in the
    // boundary cycle waits for the following frame.
    always_comb begin
        take     = load_valid && load_ready;
        active_n = (boundary && pending_valid) ? pending : active;
        pv_n     = take || (pending_valid && !boundary);
    end

    // Outputs are computed from next-cycle state so the registered values
    // line up with the slot they describe.
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (active_n[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
        digit_n = 4'd0;
        hide_n  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_n == IW'(i)) begin
                digit_n = active_n[4*i +: 4];
                hide_n  = lzb_en && (i != 0) && lead_zero[i];
            end
        end
        onehot_n = '0;
        if (state_n == S_ON && !hide_n) begin
            onehot_n = NUM_DIGITS'(1) << idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_BLANK;
            cnt           <= '0;
            idx           <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            bcd           <= 4'd0;
            digit_en      <= EN_OFF;
            blank         <= 1'b1;
            frame_done    <= 1'b0;
            load_ready    <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            active        <= active_n;
            pending_valid <= pv_n;
            if (take) begin
                pending <= load_data;
            end
            bcd        <= digit_n;
            digit_en   <= onehot_n ^ EN_OFF;
            blank      <= (state_n == S_BLANK) || hide_n;
            frame_done <= (state_n == S_ON) && (cnt_n == ON_LAST) && (idx_n == IDX_LAST);
            load_ready <= !pv_n;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0;
    logic        lzb_en = 1'b0;
    logic [3:0]  bcd;
    logic [3:0]  digit_en;
    logic        blank;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle_count = 0;
    int base = 0;

    bcd_display_scanner #(
        .NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .DIGIT_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .lzb_en(lzb_en), .bcd(bcd), .digit_en(digit_en),
        .blank(blank), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_count <= cycle_count + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  en;
        int          bcd;    // -1: not checked (dead-time slot)
        logic        bl;
        logic        fd;
        logic        rdy;
        logic        lv;     // inputs applied after the checks at this cycle
        logic [15:0] ld;
        logic        lz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int c, logic [3:0] e, int b, logic bl, logic fd, logic rdy,
                                logic lv, logic [15:0] ld, logic lz);
        vec_t v;
        v.cyc = c; v.en = e; v.bcd = b; v.bl = bl; v.fd = fd; v.rdy = rdy;
        v.lv = lv; v.ld = ld; v.lz = lz;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycle(input int t);
        while ((cycle_count - base) < t) @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e, input int b, input logic bl,
                           input logic fd, input logic rdy);
        chk({tag, " digit_en"}, int'(digit_en), int'(e));
        if (b >= 0) chk({tag, " bcd"}, int'(bcd), b);
        chk({tag, " blank"}, int'(blank), int'(bl));
        chk({tag, " frame_done"}, int'(frame_done), int'(fd));
        chk({tag, " load_ready"}, int'(load_ready), int'(rdy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Frame 0: idle, all zero
        vecs.push_back(mk(  0, 4'b0000, -1, 1, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk(  1, 4'b0000, -1, 1, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk(  2, 4'b0001,  0, 0, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk(  7, 4'b0001,  0, 0, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk(  8, 4'b0000, -1, 1, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk( 10, 4'b0010,  0, 0, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk( 18, 4'b0100,  0, 0, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk( 26, 4'b1000,  0, 0, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk( 30, 4'b1000,  0, 0, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk( 31, 4'b1000,  0, 0, 1, 1, 0, 16'h0000, 0));
        vecs.push_back(mk( 32, 4'b0000, -1, 1, 0, 1, 0, 16'h0000, 0));
        // Frame 1: load 1234 mid-frame, old digits stay until the boundary
        vecs.push_back(mk( 40, 4'b0000, -1, 1, 0, 1, 1, 16'h1234, 0));
        vecs.push_back(mk( 41, 4'b0000, -1, 1, 0, 0, 0, 16'h1234, 0));
        vecs.push_back(mk( 42, 4'b0010,  0, 0, 0, 0, 0, 16'h1234, 0));
        vecs.push_back(mk( 62, 4'b1000,  0, 0, 0, 0, 0, 16'h1234, 0));
        vecs.push_back(mk( 63, 4'b1000,  0, 0, 1, 0, 0, 16'h1234, 0));
        // Frame 2: 1234 shown; then 5678 accepted, 0090 held off while pending is full
        vecs.push_back(mk( 64, 4'b0000, -1, 1, 0, 1, 0, 16'h1234, 0));
        vecs.push_back(mk( 66, 4'b0001,  4, 0, 0, 1, 0, 16'h1234, 0));
        vecs.push_back(mk( 74, 4'b0010,  3, 0, 0, 1, 0, 16'h1234, 0));
        vecs.push_back(mk( 82, 4'b0100,  2, 0, 0, 1, 0, 16'h1234, 0));
        vecs.push_back(mk( 90, 4'b1000,  1, 0, 0, 1, 0, 16'h1234, 0));
        vecs.push_back(mk( 91, 4'b1000,  1, 0, 0, 1, 1, 16'h5678, 0));
        vecs.push_back(mk( 92, 4'b1000,  1, 0, 0, 0, 1, 16'h0090, 0));
        vecs.push_back(mk( 95, 4'b1000,  1, 0, 1, 0, 1, 16'h0090, 0));
        vecs.push_back(mk( 96, 4'b0000, -1, 1, 0, 1, 1, 16'h0090, 0));
        vecs.push_back(mk( 97, 4'b0000, -1, 1, 0, 0, 0, 16'h0090, 0));
        // Frame 3: 5678
        vecs.push_back(mk( 98, 4'b0001,  8, 0, 0, 0, 0, 16'h0090, 0));
        vecs.push_back(mk(106, 4'b0010,  7, 0, 0, 0, 0, 16'h0090, 0));
        vecs.push_back(mk(114, 4'b0100,  6, 0, 0, 0, 0, 16'h0090, 0));
        vecs.push_back(mk(122, 4'b1000,  5, 0, 0, 0, 0, 16'h0090, 0));
        vecs.push_back(mk(127, 4'b1000,  5, 0, 1, 0, 0, 16'h0090, 0));
        // Frame 4: 0090 without blanking, then lzb_en rises late in digit 3
        vecs.push_back(mk(128, 4'b0000, -1, 1, 0, 1, 0, 16'h0090, 0));
        vecs.push_back(mk(130, 4'b0001,  0, 0, 0, 1, 0, 16'h0090, 0));
        vecs.push_back(mk(138, 4'b0010,  9, 0, 0, 1, 0, 16'h0090, 0));
        vecs.push_back(mk(146, 4'b0100,  0, 0, 0, 1, 0, 16'h0090, 0));
        vecs.push_back(mk(155, 4'b1000,  0, 0, 0, 1, 1, 16'h0070, 1));
        vecs.push_back(mk(156, 4'b0000,  0, 1, 0, 0, 0, 16'h0070, 1));
        vecs.push_back(mk(159, 4'b0000,  0, 1, 1, 0, 0, 16'h0070, 1));
        // Frame 5: 0070 with blanking
        vecs.push_back(mk(162, 4'b0001,  0, 0, 0, 1, 0, 16'h0070, 1));
        vecs.push_back(mk(170, 4'b0010,  7, 0, 0, 1, 0, 16'h0070, 1));
        vecs.push_back(mk(178, 4'b0000,  0, 1, 0, 1, 0, 16'h0070, 1));
        vecs.push_back(mk(186, 4'b0000,  0, 1, 0, 1, 0, 16'h0070, 1));
        vecs.push_back(mk(187, 4'b0000,  0, 1, 0, 1, 1, 16'h0000, 1));
        vecs.push_back(mk(188, 4'b0000,  0, 1, 0, 0, 0, 16'h0000, 1));
        // Frame 6: 0000 with blanking, only digit 0 lit
        vecs.push_back(mk(194, 4'b0001,  0, 0, 0, 1, 0, 16'h0000, 1));
        vecs.push_back(mk(202, 4'b0000,  0, 1, 0, 1, 0, 16'h0000, 1));
        vecs.push_back(mk(210, 4'b0000,  0, 1, 0, 1, 0, 16'h0000, 1));
        vecs.push_back(mk(218, 4'b0000,  0, 1, 0, 1, 0, 16'h0000, 1));
        vecs.push_back(mk(219, 4'b0000,  0, 1, 0, 1, 1, 16'h00A0, 1));
        vecs.push_back(mk(220, 4'b0000,  0, 1, 0, 0, 0, 16'h00A0, 1));
        // Frame 7: 00A0, invalid digit counts as nonzero
        vecs.push_back(mk(226, 4'b0001,  0, 0, 0, 1, 0, 16'h00A0, 1));
        vecs.push_back(mk(234, 4'b0010, 10, 0, 0, 1, 0, 16'h00A0, 1));
        vecs.push_back(mk(242, 4'b0000,  0, 1, 0, 1, 0, 16'h00A0, 1));
        vecs.push_back(mk(250, 4'b0000,  0, 1, 0, 1, 0, 16'h00A0, 1));
        vecs.push_back(mk(255, 4'b0000,  0, 1, 1, 1, 0, 16'h00A0, 1));

        // Reset state
        repeat (3) @(negedge clk);
        chk_all("reset", 4'b0000, 0, 1, 0, 1);
        rst  = 1'b0;
        base = cycle_count;

        foreach (vecs[k]) begin
            wait_cycle(vecs[k].cyc);
            chk_all($sformatf("c%0d", vecs[k].cyc), vecs[k].en, vecs[k].bcd,
                    vecs[k].bl, vecs[k].fd, vecs[k].rdy);
            load_valid = vecs[k].lv;
            load_data  = vecs[k].ld;
            lzb_en     = vecs[k].lz;
        end

        // Reset during digit 2 with a load pending
        wait_cycle(260);
        load_valid = 1'b1;
        load_data  = 16'h4321;
        lzb_en     = 1'b0;
        wait_cycle(261);
        chk("mid pend load_ready", int'(load_ready), 0);
        load_valid = 1'b0;
        wait_cycle(275);
        chk_all("pre-rst d2", 4'b0100, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_all("mid-rst", 4'b0000, 0, 1, 0, 1);
        rst  = 1'b0;
        base = cycle_count;
        wait_cycle(2);
        chk_all("post-rst d0", 4'b0001, 0, 0, 0, 1);
        wait_cycle(10);
        chk_all("post-rst d1", 4'b0010, 0, 0, 0, 1);
        wait_cycle(31);
        chk_all("post-rst fd", 4'b1000, 0, 0, 1, 1);
        wait_cycle(34);
        chk_all("post-rst f1 d0", 4'b0001, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display.
- Holds NUM_DIGITS BCD digits and presents one digit at a time on bcd, for the downstream BCD-to-7-segment decoder.
- Drives a one-hot digit enable for the common anode/cathode lines.
- Adds per-slot dead time against ghosting, optional leading-zero blanking, and a tear-free load handshake: new data takes effect only at frame boundaries.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8).
- PRESCALE, 1000, clock cycles per digit slot (must be > BLANK_CYCLES).
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot (>= 1).
- DIGIT_ACTIVE_LOW, 0, 1 = digit_en lines are active-low.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- load_valid, input, 1, load_data is valid.
- load_ready, output, 1, scanner can accept a load.
- load_data, input, 4*NUM_DIGITS, packed BCD; [3:0] = digit 0 (least significant).
- lzb_en, input, 1, leading-zero blanking enable (sampled every slot).
- bcd, output, 4, BCD value of the current digit, to the decoder.
- digit_en, output, NUM_DIGITS, one-hot digit drive (polarity per DIGIT_ACTIVE_LOW).
- blank, output, 1, 1 = decoder output must be suppressed this cycle.
- frame_done, output, 1, one-cycle pulse at the end of each full scan.

Behaviour:
- All outputs are registered. Reset values:
  - digit_en all inactive.
  - bcd = 0, blank = 1, frame_done = 0, load_ready = 1.
  - Active and pending digit registers cleared, pending_valid = 0.
  - Slot index = 0, FSM in S_BLANK, slot counter = 0.
  - The first slot starts on the first cycle after rst deasserts.
- FSM states: S_BLANK, S_ON.
  - S_BLANK lasts BLANK_CYCLES cycles: digit_en all inactive, blank = 1.
  - S_ON lasts PRESCALE-BLANK_CYCLES cycles: digit_en[idx] active, bcd = active[idx], blank = 0.
  - Transitions: S_BLANK -> S_ON -> S_BLANK. A slot is exactly PRESCALE cycles; a frame is NUM_DIGITS*PRESCALE cycles.
- Index: increments at the end of each S_ON. It wraps from NUM_DIGITS-1 to 0, and the wrap cycle is the frame boundary.
- frame_done: asserts for exactly one cycle at the frame boundary, i.e. the last S_ON cycle of digit NUM_DIGITS-1.
- Load handshake:
  - load_ready = !pending_valid.
  - Transfer happens when load_valid && load_ready: load_data goes to the pending register and pending_valid sets.
  - load_data is ignored while load_ready = 0. load_valid may stay high; no data is lost, the transfer just waits.
- Commit:
  - At the frame boundary, if pending_valid, pending is copied to active and pending_valid clears. load_ready rises on the following cycle.
  - A frame never shows mixed old/new digits.
  - If a load is accepted in the boundary cycle itself (pending was empty), it commits at the next boundary.
- Leading-zero blanking: when lzb_en = 1 during S_ON, a digit idx > 0 is blanked if active[idx] and every active digit above it are zero.
  - Blanked means digit_en stays inactive, blank = 1, bcd = active[idx].
  - Digit 0 is never blanked, so the value 0 shows as "0".
- Invalid digits (values 10..15) pass through unchanged on bcd; the decoder renders them as a dash. They count as nonzero for blanking.
- DIGIT_ACTIVE_LOW = 1 inverts digit_en only. All other outputs keep their polarity.
- rst asserted mid-frame returns every output to its reset value on the next edge and drops any pending load.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
1. Reset then idle, active = 0 -> each slot has 2 cycles all-off + 6 cycles digit_en one-hot 0001, 0010, 0100, 1000 with bcd = 0. frame_done pulses every 32 cycles, first at cycle 31 after reset release.
2. Load 16'h1234 mid-frame -> load_ready drops next cycle. Digits are unchanged until the frame boundary. The next frame shows bcd 4, 3, 2, 1 for digits 0..3, and load_ready returns high one cycle after the boundary.
3. Second load while pending is full (load_valid held) -> load_ready = 0 and data is ignored. It is accepted right after the boundary commit and displayed in the frame after that.
4. lzb_en = 1, active = 16'h0070 -> digits 2 and 3 are blanked (digit_en inactive, blank = 1). Digit 1 shows 7 and digit 0 shows 0. With active = 16'h0000 only digit 0 lights, showing 0.
5. active = 16'h00A0, lzb_en = 1 -> digit 1 shows bcd = 10 with blank = 0 (not blanked). Digits 2 and 3 are blanked.
6. rst asserted during an S_ON slot of digit 2 with a load pending -> the next cycle shows reset values, load_ready = 1, and the display restarts at digit 0 showing 0.
